uart_rx: RTL

Serial receiver for the UART path: consumes the single-wire line driven by the UART transmitter and reassembles its frames into bytes. Frame format matches the transmitter:
- one start bit (0)
- 8 data bits, LSB first
- one parity bit (when `PARITY_EN=1`)
- one stop bit (1)

Received bytes sit in a one-entry holding register behind a valid/ready handshake, with per-byte parity, framing and overrun status. The block sits between the line input pin and the byte-consuming logic.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_sync.sv | 27 ++
 rtl/uart_rx.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit and receive paths.
//   uart_state_t    - frame state encoding (IDLE, START, DATA, PARITY, STOP)
//   DATA_BITS       - data bits per frame
//   STOP_VAL        - line level of a valid stop bit
//   parity_mismatch - 1 when a sampled parity bit disagrees with the data
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  localparam int unsigned DATA_BITS = 8;
  localparam logic        STOP_VAL  = 1'b1;

  function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] data,
                                           input logic                 par_bit,
                                           input logic                 odd);
    return (^data) ^ par_bit ^ odd;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// uart_sync: two-flop synchronizer for an asynchronous single-bit input.
//   RST_VAL  - value both flops take during reset
//   clk, rst - clock and asynchronous active-high reset
//   d        - asynchronous input
//   q        - synchronized output, two cycles behind d
module uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART serial receiver with a one-entry valid/ready holding register.
//   Frame: start(0), 8 data bits LSB first, optional parity, stop(1).
//   CLKS_PER_BIT - clocks per serial bit (1..255)
//   PARITY_EN    - 1: parity bit present and checked
//   PARITY_ODD   - 0: even parity, 1: odd parity
//   clk, rst     - clock and asynchronous active-high reset
//   rx_in        - asynchronous serial line, idles high
//   data_ready   - consumer accepts data_out while data_valid is high
//   data_out     - received byte
//   data_valid   - holding register full
//   parity_err   - parity mismatch for the held byte
//   frame_err    - stop bit sampled low for the held byte
//   overrun      - one-cycle pulse when a completed frame is dropped
//   busy         - receiver is inside a frame
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter bit          PARITY_EN    = 1'b1,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  input  logic       data_ready,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam logic [7:0] HALF = 8'((CLKS_PER_BIT - 1) / 2);
  localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);

  uart_state_t          state;
  logic [7:0]           cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 par_err_q;
  logic                 rx_s;
  logic                 sample;
  logic                 last;

  uart_sync #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_in),
    .q   (rx_s)
  );

  assign sample = (cnt == HALF);
  assign last   = (cnt == LAST);
  assign busy   = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      par_err_q  <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (data_valid && data_ready)
        data_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          // The detection cycle is cnt 0 of the start bit; with HALF == 0 it is
          // also the start-bit sample point, so the low level already validates it.
          if (!rx_s) begin
            bit_idx <= '0;
            if (LAST == 8'd0) begin
              state <= ST_DATA;
              cnt   <= '0;
            end else begin
              state <= ST_START;
              cnt   <= 8'd1;
            end
          end
        end

        ST_START: begin
          if (sample && rx_s) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (last) begin
            state <= ST_DATA;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        ST_DATA: begin
          if (sample)
            shift[bit_idx] <= rx_s;
          if (last) begin
            cnt <= '0;
            if (bit_idx == 3'(DATA_BITS - 1))
              state <= PARITY_EN ? ST_PARITY : ST_STOP;
            else
              bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        ST_PARITY: begin
          if (sample)
            par_err_q <= parity_mismatch(shift, rx_s, PARITY_ODD);
          if (last) begin
            state <= ST_STOP;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        ST_STOP: begin
          // Frame completes at the stop sample point; the tail of the stop bit is
          // spent in IDLE so an immediately following start bit is not missed.
          if (sample) begin
            state <= ST_IDLE;
            cnt   <= '0;
            if (!data_valid || data_ready) begin
              data_out   <= shift;
              data_valid <= 1'b1;
              parity_err <= PARITY_EN ? par_err_q : 1'b0;
              frame_err  <= (rx_s != STOP_VAL);
            end else begin
              overrun <= 1'b1;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
